// File: rtl/if_fetch_queue_pkg.sv
// Shared fetch-path constants, mirroring the MIPS.vh header values used by
// the fetch queue and its pointer controller.
package if_fetch_queue_pkg;

    localparam int unsigned PC_LENGTH   = 32;
    localparam int unsigned INST_LENGTH = 32;

    localparam logic ENABLE  = 1'b1;
    localparam logic DISABLE = 1'b0;

    localparam logic [INST_LENGTH-1:0] NOP_INST = 32'h0000_0000;

endpackage

// File: rtl/sync_fifo_ctrl.sv
// Pointer/count controller for a power-of-two circular buffer.
// Produces qualified push/pop strobes plus registered full and occupied flags.
module sync_fifo_ctrl
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             push_req,
    input  logic             pop_req,
    output logic             push_c,
    output logic             pop_c,
    output logic [PTR_W-1:0] wr_ptr,
    output logic [PTR_W-1:0] rd_ptr,
    output logic [PTR_W-1:0] rd_ptr_nxt_c,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] count_nxt_c,
    output logic             full,
    output logic             occupied
);

    logic [PTR_W-1:0] wr_ptr_nxt;

    // A full queue refuses pushes even when a pop frees a slot this cycle.
    assign push_c = push_req & ~full & ~flush;
    assign pop_c  = pop_req & occupied & ~flush;

    always_comb begin
        wr_ptr_nxt   = wr_ptr;
        rd_ptr_nxt_c = rd_ptr;
        count_nxt_c  = count;
        if (flush) begin
            wr_ptr_nxt   = '0;
            rd_ptr_nxt_c = '0;
            count_nxt_c  = '0;
        end else begin
            if (push_c) begin
                wr_ptr_nxt = wr_ptr + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_nxt_c = rd_ptr + PTR_W'(1);
            end
            count_nxt_c = count + CNT_W'(push_c) - CNT_W'(pop_c);
        end
    end

    // Flags are registered from the next count so hold/valid carry no comb path.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            full     <= DISABLE;
            occupied <= DISABLE;
        end else begin
            wr_ptr   <= wr_ptr_nxt;
            rd_ptr   <= rd_ptr_nxt_c;
            count    <= count_nxt_c;
            full     <= (count_nxt_c == CNT_W'(DEPTH));
            occupied <= (count_nxt_c != '0);
        end
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch queue between InstMem and decode: buffers {pc, inst}
// pairs, back-pressures fetch with hold, and drops everything on a redirect.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned PC_W   = PC_LENGTH,
    parameter int unsigned INST_W = INST_LENGTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              inValid,
    input  logic [PC_W-1:0]   inPc,
    input  logic [INST_W-1:0] inInst,
    output logic              hold,
    input  logic              flush,
    output logic              outValid,
    output logic [PC_W-1:0]   outPc,
    output logic [INST_W-1:0] outInst,
    input  logic              outReady,
    output logic [CNT_W-1:0]  count
);

    logic [PC_W-1:0]   mem_pc   [DEPTH];
    logic [INST_W-1:0] mem_inst [DEPTH];

    logic              push_c;
    logic              pop_c;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  rd_ptr_nxt_c;
    logic [CNT_W-1:0]  count_nxt_c;
    logic [PC_W-1:0]   head_pc_nxt;
    logic [INST_W-1:0] head_inst_nxt;

    sync_fifo_ctrl #(
        .DEPTH (DEPTH)
    ) u_ctrl (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push_req     (inValid),
        .pop_req      (outReady),
        .push_c       (push_c),
        .pop_c        (pop_c),
        .wr_ptr       (wr_ptr),
        .rd_ptr       (rd_ptr),
        .rd_ptr_nxt_c (rd_ptr_nxt_c),
        .count        (count),
        .count_nxt_c  (count_nxt_c),
        .full         (hold),
        .occupied     (outValid)
    );

    // Storage needs no reset: occupancy alone decides what is visible.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_pc[wr_ptr]   <= inPc;
            mem_inst[wr_ptr] <= inInst;
        end
    end

    // Next head; a push into a slot that becomes the head bypasses storage.
    always_comb begin
        head_pc_nxt   = '0;
        head_inst_nxt = INST_W'(NOP_INST);
        if (count_nxt_c != '0) begin
            if (push_c && (wr_ptr == rd_ptr_nxt_c)) begin
                head_pc_nxt   = inPc;
                head_inst_nxt = inInst;
            end else begin
                head_pc_nxt   = mem_pc[rd_ptr_nxt_c];
                head_inst_nxt = mem_inst[rd_ptr_nxt_c];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            outPc   <= '0;
            outInst <= INST_W'(NOP_INST);
        end else begin
            outPc   <= head_pc_nxt;
            outInst <= head_inst_nxt;
        end
    end

    logic unused_pop;
    assign unused_pop = pop_c;

endmodule

// File: tb/tb_if_fetch_queue.sv
// Self-checking bench for if_fetch_queue: directed scenarios plus random
// traffic, all compared against a queue-based reference model.
module tb_if_fetch_queue;

    localparam int unsigned DEPTH = 4;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        inValid;
    logic [31:0] inPc;
    logic [31:0] inInst;
    logic        hold;
    logic        flush;
    logic        outValid;
    logic [31:0] outPc;
    logic [31:0] outInst;
    logic        outReady;
    logic [2:0]  count;

    int          checks = 0;
    int          errors = 0;
    ent_t        mq[$];
    logic [31:0] fpc;
    logic        acc;

    always #5 clk = ~clk;

    if_fetch_queue #(
        .DEPTH  (DEPTH),
        .PC_W   (32),
        .INST_W (32)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .inValid  (inValid),
        .inPc     (inPc),
        .inInst   (inInst),
        .hold     (hold),
        .flush    (flush),
        .outValid (outValid),
        .outPc    (outPc),
        .outInst  (outInst),
        .outReady (outReady),
        .count    (count)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_model();
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
        exp_pc   = (mq.size() != 0) ? mq[0].pc : 32'h0;
        exp_inst = (mq.size() != 0) ? mq[0].inst : 32'h0;
        check("count", 64'(count), 64'(mq.size()));
        check("outValid", 64'(outValid), 64'(mq.size() != 0));
        check("hold", 64'(hold), 64'(mq.size() == DEPTH));
        check("outPc", 64'(outPc), 64'(exp_pc));
        check("outInst", 64'(outInst), 64'(exp_inst));
    endtask

    // One clock: drive inputs, advance the model at the edge, check after it.
    task automatic step(input logic v, input logic [31:0] pc, input logic rdy,
                        input logic fl, input logic r, output logic accepted);
        logic [31:0] inst;
        logic        do_push;
        logic        do_pop;
        inst = $urandom();
        @(negedge clk);
        rst      = r;
        inValid  = v;
        inPc     = pc;
        inInst   = inst;
        outReady = rdy;
        flush    = fl;
        do_push  = v && (mq.size() < DEPTH) && !fl && !r;
        do_pop   = rdy && (mq.size() != 0) && !fl && !r;
        @(posedge clk);
        if (r || fl) begin
            mq.delete();
        end else begin
            if (do_pop) void'(mq.pop_front());
            if (do_push) mq.push_back('{pc, inst});
        end
        accepted = do_push;
        #1;
        check_model();
    endtask

    // Fetch stage behaviour: PC only advances when the word was taken.
    task automatic fetch(input logic rdy);
        logic a;
        step(1'b1, fpc, rdy, 1'b0, 1'b0, a);
        if (a) fpc = fpc + 32'd4;
    endtask

    initial begin
        rst = 1'b1; inValid = 1'b0; inPc = '0; inInst = '0;
        outReady = 1'b0; flush = 1'b0;

        // Reset then idle
        step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1, acc);
        check("rst_count", 64'(count), 64'd0);
        check("rst_inst", 64'(outInst), 64'd0);
        step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Fill with decode stalled, then drain
        fpc = 32'h0;
        repeat (4) fetch(1'b0);
        check("fill_hold", 64'(hold), 64'd1);
        fetch(1'b0);
        check("full_count", 64'(count), 64'd4);
        fetch(1'b1);
        check("pop_from_full_pc", 64'(outPc), 64'h4);
        check("pop_from_full_count", 64'(count), 64'd3);
        repeat (3) fetch(1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b1, 1'b0, 1'b0, acc);

        // Streaming one in / one out per clock
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        fpc = 32'h0;
        for (int i = 0; i < 10; i++) begin
            fetch(1'b1);
            check("stream_pc", 64'(outPc), 64'(32'(4 * i)));
            check("stream_count", 64'(count), 64'd1);
        end

        // Flush with three entries and a same-cycle push
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        fpc = 32'h0;
        repeat (3) fetch(1'b0);
        step(1'b1, 32'h0C, 1'b1, 1'b1, 1'b0, acc);
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(outValid), 64'd0);
        step(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, acc);
        check("redirect_head", 64'(outPc), 64'h40);

        // Full with simultaneous pop and push
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        fpc = 32'h100;
        repeat (4) fetch(1'b0);
        fetch(1'b1);
        check("full_poppush_count", 64'(count), 64'd3);
        fetch(1'b0);
        check("represent_count", 64'(count), 64'd4);

        // Reset with two entries while decode is ready
        step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0, acc);
        repeat (2) fetch(1'b0);
        step(1'b1, fpc, 1'b1, 1'b0, 1'b1, acc);
        check("midrst_count", 64'(count), 64'd0);
        check("midrst_pc", 64'(outPc), 64'd0);

        // Random traffic with redirects and occasional resets
        fpc = 32'h1000;
        for (int i = 0; i < 3000; i++) begin
            logic v, rdy, fl, r, a;
            int   bias;
            bias = (i / 200) % 3;
            v    = ($urandom_range(0, 3) != 0);
            rdy  = (bias == 0) ? ($urandom_range(0, 3) == 0) :
                   (bias == 1) ? ($urandom_range(0, 3) != 0) : 1'($urandom());
            fl   = ($urandom_range(0, 15) == 0);
            r    = ($urandom_range(0, 127) == 0);
            step(v, fpc, rdy, fl, r, a);
            if (fl || r) fpc = {$urandom_range(0, 16'hFFFF), 2'b00};
            else if (a) fpc = fpc + 32'd4;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Instruction fetch queue between the instruction memory (InstMem) read port and the decode stage. It buffers up to DEPTH fetched {pc, instruction} pairs and presents them to decode through a valid/ready handshake. It back-pressures the fetch stage with `hold` when full, and discards all buffered words when a jump redirect is taken. This decouples PC sequencing from decode stalls without changing the fetch stage's one-word-per-clock behaviour.

## Interface
Parameters:
- `DEPTH`, 4: number of entries. Must be a power of two, ≥ 2.
- `PC_W`, `PC_LENGTH`: PC width.
- `INST_W`, `INST_LENGTH` (32): instruction width.

Ports:
- `clk`  in  1: clock; all state updates on posedge.
- `rst`  in  1: reset, synchronous, active-high.
- `inValid`  in  1: fetch word present this cycle (fetch stage's romCe asserted).
- `inPc`  in  PC_W: PC of the word on `inInst`.
- `inInst`  in  INST_W: instruction read from InstMem.
- `hold`  out  1: queue full; fetch stage must not advance PC.
- `flush`  in  1: redirect taken (same signal as the jump enable to fetch); discard contents.
- `outValid`  out  1: head entry valid.
- `outPc`  out  PC_W: PC of head entry.
- `outInst`  out  INST_W: instruction of head entry.
- `outReady`  in  1: decode accepts head this cycle.
- `count`  out  clog2(DEPTH+1): number of occupied entries.

## Operation
- Circular buffer: storage array, `wrPtr`/`rdPtr` of clog2(DEPTH) bits wrapping modulo DEPTH, and `count` register.
- push = `inValid` & !full & !`flush`. Writes {inPc, inInst} at `wrPtr`; `wrPtr`+1.
- pop = `outValid` & `outReady` & !`flush`. `rdPtr`+1.
- `count` next = count + push − pop. Push and pop in the same cycle leave `count` unchanged.
- full = (count == DEPTH); `hold` = full. `hold` depends only on registered state, never on `outReady`, so there is no combinational path from decode to fetch.
- When full, push is refused even if a pop occurs in the same cycle. The fetch stage holds its PC, so the same word is re-presented next cycle.
- `flush`: `wrPtr`, `rdPtr` and `count` go to 0. A same-cycle push or pop is ignored. Storage contents are don't-care.
- Priority: `rst` > `flush` > push/pop.
- `outValid` = (count != 0). `outPc`/`outInst` = entry at `rdPtr` when valid. When empty they are forced to 0 (instruction 0x00000000 = NOP).
- `inValid` low: no push. `inPc`/`inInst` are ignored.
- `outReady` while empty has no effect.

## Timing
- Reset values: `count` 0, `outValid` 0, `outPc` 0, `outInst` 0, `hold` 0, both pointers 0.
- Reset mid-operation discards all entries at the same edge, as flush does.
- Latency: a word pushed at edge N appears on the outputs after edge N if the queue was empty. Minimum in-to-out latency is one clock; there is no combinational bypass.
- Throughput: one push plus one pop per clock sustained while 0 < count < DEPTH.
- `hold` asserts in the cycle after the push that fills the queue. It deasserts in the cycle after the first pop from full.
- Flush at edge N: `outValid` = 0 and `hold` = 0 after edge N. The first post-redirect word can be pushed at edge N+1.
- Pointer wrap: pointers wrap from DEPTH−1 to 0 with no bubble.

## Structure
- `PC_LENGTH`, `INST_LENGTH`, `ENABLE`/`DISABLE` and `NOP_INST` (32'h0) come from the shared MIPS.vh header. No new local constants except the derived pointer width.
- Natural sub-module: `sync_fifo_ctrl`, which holds the pointer/count logic and produces full/empty. `if_fetch_queue` instantiates it, owns the storage array and output zeroing, and can later be reused by the load/store buffer.

## Test plan
- Reset then idle: after `rst` high for 1 clock, verify `count`=0, `outValid`=0, `outInst`=0, `hold`=0.
- Fill with `outReady`=0: push pc 0x00,0x04,0x08,0x0C. Expect `hold`=1 after the 4th edge. A 5th word 0x10 is refused and `count` stays 4. Then set `outReady`=1: pops come out in order 0x00..0x0C, and 0x10 is accepted once `hold` drops.
- Streaming: `inValid`=1 and `outReady`=1 for 10 clocks starting at pc 0x00. Expect `count` steady at 1, one word out per clock, with pointers wrapping past entry 3 and no gaps.
- Flush with 3 entries plus a same-cycle push (pc 0x0C): after the edge, `count`=0 and `outValid`=0. Next push pc 0x40 appears as head one clock later.
- Full with simultaneous pop and push: the pop is taken and the push is refused. `count` goes 4→3, then the re-presented word is accepted on the next edge.
- `rst` asserted with 2 entries while `outReady`=1: all outputs return to reset values at that edge, with no pop observed.
